// File: rtl/raster_scan_timer.sv
// raster_scan_timer: measures the x-axis mirror line period from the opto
// strobe. It sequences the vertical DISPLAY/RETURN scan and spreads NUM_COLS
// pixel slots across each measured line with a DDA.
// Optional watchdog: define RASTER_SCAN_TIMEOUT_EN to enable it.
module raster_scan_timer #(
  parameter int NUM_ROWS       = 240,
  parameter int NUM_COLS       = 320,
  parameter int Y_RETURN_LINES = 25,
  parameter int PERIOD_W       = 20,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        x_axis_stb,
  input  logic                        enable,
  output logic [$clog2(NUM_ROWS)-1:0] row,
  output logic [$clog2(NUM_COLS)-1:0] col,
  output logic                        pixel_valid,
  output logic                        line_start,
  output logic                        frame_start,
  output logic                        y_return,
  output logic [PERIOD_W-1:0]         line_period,
  output logic                        stb_timeout
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int RET_W = (Y_RETURN_LINES > 1) ? $clog2(Y_RETURN_LINES) : 1;
  localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

  // Elaboration-time parameter sanity checks
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES >= (64'd1 << PERIOD_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be below 2**PERIOD_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DISPLAY = 2'd1,
    ST_RETURN  = 2'd2
  } state_t;

  state_t                 state_r, state_next_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   stb_d_r;
  logic                   edge_r;
  logic [PERIOD_W-1:0]    cnt_r;
  logic [PERIOD_W-1:0]    line_period_r;
  logic                   seen_r;
  logic                   period_valid_r;
  logic                   valid_next_s;
  logic                   sat_s;
  logic                   timeout_s;
  logic [ROW_W-1:0]       row_r, row_next_s;
  logic [RET_W-1:0]       ret_r, ret_next_s;
  logic                   ls_s, fs_s;
  logic                   line_start_r, frame_start_r, y_return_r;
  logic [COL_W-1:0]       col_r;
  logic                   pixel_valid_r;
  logic [PERIOD_W:0]      acc_r, sum_s;
  logic                   stb_timeout_r;

  // Synchronise the opto strobe and register its rising edge
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_r  <= '0;
      stb_d_r <= 1'b0;
      edge_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], x_axis_stb};
      stb_d_r <= sync_r[SYNC_STAGES-1];
      edge_r  <= sync_r[SYNC_STAGES-1] & ~stb_d_r;
    end
  end

  assign sat_s = (cnt_r == CNT_MAX);

`ifdef RASTER_SCAN_TIMEOUT_EN
  assign timeout_s = ~edge_r & (cnt_r == PERIOD_W'(TIMEOUT_CYCLES));

  // Sticky watchdog flag, cleared only by reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stb_timeout_r <= 1'b0;
    end else if (timeout_s) begin
      stb_timeout_r <= 1'b1;
    end
  end
`else
  assign timeout_s     = 1'b0;
  assign stb_timeout_r = 1'b0;
`endif

  // Period validity: the first edge after clearing only restarts the count,
  // a saturated count is not a usable period
  always_comb begin
    valid_next_s = period_valid_r;
    if (timeout_s) begin
      valid_next_s = 1'b0;
    end else if (edge_r) begin
      valid_next_s = seen_r & ~sat_s;
    end else begin
      valid_next_s = period_valid_r;
    end
  end

  // Saturating line-period counter and period latch
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_r          <= '0;
      line_period_r  <= '0;
      seen_r         <= 1'b0;
      period_valid_r <= 1'b0;
    end else begin
      period_valid_r <= valid_next_s;
      if (edge_r) begin
        cnt_r  <= {{(PERIOD_W-1){1'b0}}, 1'b1};
        seen_r <= 1'b1;
        if (seen_r) begin
          line_period_r <= cnt_r;
        end
      end else begin
        if (!sat_s) begin
          cnt_r <= cnt_r + {{(PERIOD_W-1){1'b0}}, 1'b1};
        end
        if (timeout_s) begin
          seen_r <= 1'b0;
        end
      end
    end
  end

  // Vertical scan next-state, row/return counters and start pulses
  always_comb begin
    state_next_s = state_r;
    row_next_s   = row_r;
    ret_next_s   = ret_r;
    ls_s         = 1'b0;
    fs_s         = 1'b0;
    if (timeout_s) begin
      state_next_s = ST_IDLE;
      row_next_s   = '0;
    end else if (!enable) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (edge_r && valid_next_s) begin
            state_next_s = ST_DISPLAY;
            row_next_s   = '0;
            ls_s         = 1'b1;
            fs_s         = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_DISPLAY: begin
          if (edge_r) begin
            if (row_r == ROW_W'(NUM_ROWS - 1)) begin
              state_next_s = ST_RETURN;
              ret_next_s   = '0;
            end else begin
              row_next_s = row_r + ROW_W'(1);
              ls_s       = 1'b1;
            end
          end else begin
            state_next_s = ST_DISPLAY;
          end
        end
        ST_RETURN: begin
          if (edge_r) begin
            if (ret_r == RET_W'(Y_RETURN_LINES - 1)) begin
              state_next_s = ST_DISPLAY;
              row_next_s   = '0;
              ls_s         = 1'b1;
              fs_s         = 1'b1;
            end else begin
              ret_next_s = ret_r + RET_W'(1);
            end
          end else begin
            state_next_s = ST_RETURN;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register and registered scan outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      row_r         <= '0;
      ret_r         <= '0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      y_return_r    <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      row_r         <= row_next_s;
      ret_r         <= ret_next_s;
      line_start_r  <= ls_s;
      frame_start_r <= fs_s;
      y_return_r    <= (state_next_s == ST_RETURN);
    end
  end

  assign sum_s = acc_r + (PERIOD_W+1)'(NUM_COLS);

  // Column DDA: NUM_COLS slots spread over line_period clocks
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      col_r         <= '0;
      acc_r         <= '0;
      pixel_valid_r <= 1'b0;
    end else if (ls_s) begin
      col_r         <= '0;
      acc_r         <= '0;
      pixel_valid_r <= 1'b1;
    end else if (state_next_s != ST_DISPLAY) begin
      pixel_valid_r <= 1'b0;
    end else if (sum_s >= {1'b0, line_period_r}) begin
      acc_r <= sum_s - {1'b0, line_period_r};
      if (col_r == COL_W'(NUM_COLS - 1)) begin
        pixel_valid_r <= 1'b0;
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end else begin
      acc_r <= sum_s;
    end
  end

  assign row         = row_r;
  assign col         = col_r;
  assign pixel_valid = pixel_valid_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign y_return    = y_return_r;
  assign line_period = line_period_r;
  assign stb_timeout = stb_timeout_r;

endmodule

// File: tb/tb_raster_scan_timer.sv
// Directed bench for raster_scan_timer (4 rows, 8 cols, 2 return lines,
// 500-clock watchdog, 100-clock strobe period with a 10-clock high phase).
module tb_raster_scan_timer;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        x_axis_stb = 1'b0;
  logic        enable = 1'b1;
  logic [1:0]  row;
  logic [2:0]  col;
  logic        pixel_valid, line_start, frame_start, y_return, stb_timeout;
  logic [19:0] line_period;

  int n_cmp = 0;
  int n_bad = 0;
  int phase = 0;
  bit stb_on = 1'b0;

  raster_scan_timer #(
    .NUM_ROWS(4), .NUM_COLS(8), .Y_RETURN_LINES(2), .PERIOD_W(20),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(500)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .x_axis_stb(x_axis_stb), .enable(enable),
    .row(row), .col(col), .pixel_valid(pixel_valid), .line_start(line_start),
    .frame_start(frame_start), .y_return(y_return), .line_period(line_period),
    .stb_timeout(stb_timeout)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // one clock: drive strobe for this phase, then sample 1 after the edge
  task automatic step();
    x_axis_stb = stb_on && (phase < 10);
    phase = (phase == 99) ? 0 : phase + 1;
    @(posedge CLOCK_50);
    #1;
  endtask

  // advance until the outputs for the next strobe edge are visible (phase 4)
  task automatic next_edge();
    for (int i = 0; i < 100; i++) begin
      step();
      if (phase == 4) break;
    end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    reset = 1'b1; stb_on = 1'b0; phase = 0;
    step(); step();
    got = {row, col, pixel_valid, line_start, frame_start, y_return, stb_timeout, line_period};
    n_cmp++;
    if (got !== 32'd0) begin n_bad++; $display("FAIL reset_hold got %h want 0", got); end
    reset = 1'b0;
    step();
    got = {row, col, pixel_valid, line_start, frame_start, y_return, stb_timeout, line_period};
    n_cmp++;
    if (got !== 32'd0) begin n_bad++; $display("FAIL reset_release got %h want 0", got); end
  endtask

  task automatic test_frame();
    phase = 0; stb_on = 1'b1;
    next_edge();
    n_cmp++;
    if ({line_start, frame_start, pixel_valid, y_return, line_period} !== 24'd0) begin
      n_bad++; $display("FAIL edge1_quiet got ls=%b fs=%b pv=%b yr=%b lp=%0d want all 0",
                        line_start, frame_start, pixel_valid, y_return, line_period);
    end
    next_edge();
    n_cmp++;
    if (line_period !== 20'd100) begin n_bad++; $display("FAIL edge2_period got %0d want 100", line_period); end
    n_cmp++;
    if ({frame_start, line_start, row, pixel_valid, y_return, col} !== 9'b11_00_1_0_000) begin
      n_bad++; $display("FAIL edge2_start got fs=%b ls=%b row=%0d pv=%b yr=%b col=%0d want 1 1 0 1 0 0",
                        frame_start, line_start, row, pixel_valid, y_return, col);
    end
    for (int r = 1; r < 4; r++) begin
      logic [1:0] rr;
      rr = 2'(r);
      next_edge();
      n_cmp++;
      if ({frame_start, line_start, row, y_return} !== {1'b0, 1'b1, rr, 1'b0}) begin
        n_bad++; $display("FAIL row_step got fs=%b ls=%b row=%0d yr=%b want 0 1 %0d 0",
                          frame_start, line_start, row, y_return, r);
      end
    end
    next_edge();
    n_cmp++;
    if ({y_return, pixel_valid, line_start, frame_start} !== 4'b1000) begin
      n_bad++; $display("FAIL edge6_return got yr=%b pv=%b ls=%b fs=%b want 1 0 0 0",
                        y_return, pixel_valid, line_start, frame_start);
    end
    next_edge();
    n_cmp++;
    if ({y_return, line_start} !== 2'b10) begin
      n_bad++; $display("FAIL edge7_return got yr=%b ls=%b want 1 0", y_return, line_start);
    end
    next_edge();
    n_cmp++;
    if ({frame_start, line_start, row, y_return, pixel_valid} !== 6'b11_00_0_1) begin
      n_bad++; $display("FAIL edge8_frame got fs=%b ls=%b row=%0d yr=%b pv=%b want 1 1 0 0 1",
                        frame_start, line_start, row, y_return, pixel_valid);
    end
  endtask

  task automatic test_dda();
    for (int n = 1; n <= 99; n++) begin
      step();
      n_cmp++;
      if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL dda_pv n=%0d got %b want 1", n, pixel_valid); end
      if (n == 1) begin
        n_cmp++;
        if ({line_start, frame_start} !== 2'b00) begin
          n_bad++; $display("FAIL pulse_width got ls=%b fs=%b want 0 0", line_start, frame_start);
        end
      end
      if (n == 12 || n == 13 || n == 87 || n == 88 || n == 99) begin
        logic [2:0] exp_col;
        exp_col = (n == 12) ? 3'd0 : (n == 13) ? 3'd1 : (n == 87) ? 3'd6 : 3'd7;
        n_cmp++;
        if (col !== exp_col) begin n_bad++; $display("FAIL dda_col n=%0d got %0d want %0d", n, col, exp_col); end
      end
      if (n == 99) begin
        n_cmp++;
        if (line_start !== 1'b0) begin n_bad++; $display("FAIL latency_early got ls=%b want 0", line_start); end
      end
    end
    step();
    n_cmp++;
    if ({line_start, col, row} !== 6'b1_000_01) begin
      n_bad++; $display("FAIL dda_restart got ls=%b col=%0d row=%0d want 1 0 1", line_start, col, row);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] got;
    next_edge();
    repeat (38) step();
    n_cmp++;
    if ({row, col, pixel_valid} !== 6'b10_011_1) begin
      n_bad++; $display("FAIL pre_reset_pos got row=%0d col=%0d pv=%b want 2 3 1", row, col, pixel_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    got = {row, col, pixel_valid, line_start, frame_start, y_return, stb_timeout, line_period};
    n_cmp++;
    if (got !== 32'd0) begin n_bad++; $display("FAIL mid_reset got %h want 0", got); end
    next_edge();
    n_cmp++;
    if ({line_start, frame_start, line_period} !== 22'd0) begin
      n_bad++; $display("FAIL post_reset_edge1 got ls=%b fs=%b lp=%0d want 0 0 0", line_start, frame_start, line_period);
    end
    next_edge();
    n_cmp++;
    if ({frame_start, line_start, row, line_period} !== {2'b11, 2'd0, 20'd100}) begin
      n_bad++; $display("FAIL post_reset_edge2 got fs=%b ls=%b row=%0d lp=%0d want 1 1 0 100",
                        frame_start, line_start, row, line_period);
    end
  endtask

  task automatic test_enable_drop();
    next_edge();
    repeat (20) step();
    n_cmp++;
    if ({row, pixel_valid} !== 3'b01_1) begin
      n_bad++; $display("FAIL pre_drop got row=%0d pv=%b want 1 1", row, pixel_valid);
    end
    enable = 1'b0;
    step();
    n_cmp++;
    if ({pixel_valid, line_start, y_return} !== 3'b000) begin
      n_bad++; $display("FAIL enable_drop got pv=%b ls=%b yr=%b want 0 0 0", pixel_valid, line_start, y_return);
    end
    repeat (49) step();
    enable = 1'b1;
    next_edge();
    n_cmp++;
    if ({frame_start, line_start, row, pixel_valid, line_period} !== {2'b11, 2'd0, 1'b1, 20'd100}) begin
      n_bad++; $display("FAIL reenable got fs=%b ls=%b row=%0d pv=%b lp=%0d want 1 1 0 1 100",
                        frame_start, line_start, row, pixel_valid, line_period);
    end
  endtask

  task automatic test_watchdog();
    next_edge();
    next_edge();
    n_cmp++;
    if (row !== 2'd2) begin n_bad++; $display("FAIL wd_start_row got %0d want 2", row); end
    stb_on = 1'b0;
`ifdef RASTER_SCAN_TIMEOUT_EN
    repeat (499) step();
    n_cmp++;
    if ({stb_timeout, row} !== 3'b0_10) begin
      n_bad++; $display("FAIL wd_early got to=%b row=%0d want 0 2", stb_timeout, row);
    end
    step();
    n_cmp++;
    if ({stb_timeout, pixel_valid, row, y_return} !== 5'b1_0_00_0) begin
      n_bad++; $display("FAIL wd_fire got to=%b pv=%b row=%0d yr=%b want 1 0 0 0",
                        stb_timeout, pixel_valid, row, y_return);
    end
    phase = 0; stb_on = 1'b1;
    next_edge();
    n_cmp++;
    if ({line_start, frame_start, stb_timeout} !== 3'b001) begin
      n_bad++; $display("FAIL wd_resume1 got ls=%b fs=%b to=%b want 0 0 1", line_start, frame_start, stb_timeout);
    end
    next_edge();
    n_cmp++;
    if ({frame_start, line_start, row, stb_timeout, line_period} !== {2'b11, 2'd0, 1'b1, 20'd100}) begin
      n_bad++; $display("FAIL wd_resume2 got fs=%b ls=%b row=%0d to=%b lp=%0d want 1 1 0 1 100",
                        frame_start, line_start, row, stb_timeout, line_period);
    end
`else
    repeat (600) step();
    n_cmp++;
    if ({stb_timeout, row} !== 3'b0_10) begin
      n_bad++; $display("FAIL stall_hold got to=%b row=%0d want 0 2", stb_timeout, row);
    end
    phase = 0; stb_on = 1'b1;
    next_edge();
    n_cmp++;
    if ({row, line_start, line_period} !== {2'd3, 1'b1, 20'd604}) begin
      n_bad++; $display("FAIL stall_resume got row=%0d ls=%b lp=%0d want 3 1 604", row, line_start, line_period);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame();
    test_dda();
    test_mid_reset();
    test_enable_drop();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got still running want finished");
    $fatal(1, "simulation time limit expired");
  end

endmodule
